uart_cmd_bridge: RTL and testbench

Command responder on the host-facing UART byte stream. Consumes bytes from the UART receive handshake, decodes read/write commands issued by the host, performs single 32-bit accesses on a simple valid/ready memory bus, and returns response bytes through the UART transmit handshake. It is the device end of the host debug protocol: the host initiates, this block answers.

---
 rtl/uart_cmd_bridge.sv | 163 ++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge.sv
// Device-side responder for the host debug protocol: decodes 'W'/'R' commands from the UART
// byte stream, performs one 32-bit bus access, and answers. Optional ARGS timeout: BRIDGE_TIMEOUT_EN.
module uart_cmd_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        abort
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARGS = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  state;
    logic [2:0]  idx;
    logic        op_write;
    logic        op_bad;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rx_fire;
    logic        tmo_hit;
    logic [2:0]  args_last;
    logic [2:0]  resp_last;

    assign rx_ready  = (state == S_IDLE) || (state == S_ARGS);
    assign tx_valid  = (state == S_RESP);
    assign mem_valid = (state == S_MEM);
    assign mem_we    = op_write;
    assign mem_addr  = addr;
    assign mem_wdata = wdata;
    assign rx_fire   = rx_valid && rx_ready;
    assign args_last = op_write ? 3'd5 : 3'd1;
    assign resp_last = (op_write || op_bad) ? 3'd0 : 3'd3;

`ifdef BRIDGE_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        abort_q;

    // Counter is held at zero outside ARGS, so entering ARGS always starts from a clean count.
    assign tmo_hit = (state == S_ARGS) && !rx_fire && (tmo_cnt == TIMEOUT_CYCLES - 1);
    assign abort   = abort_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= tmo_hit;
            if (state != S_ARGS || rx_fire || tmo_hit) tmo_cnt <= '0;
            else                                        tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = |TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
    assign abort   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            op_write <= 1'b0;
            op_bad   <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        idx <= '0;
                        if (rx_byte == 8'h57) begin
                            op_write <= 1'b1;
                            op_bad   <= 1'b0;
                            state    <= S_ARGS;
                        end else if (rx_byte == 8'h52) begin
                            op_write <= 1'b0;
                            op_bad   <= 1'b0;
                            state    <= S_ARGS;
                        end else begin
                            op_write <= 1'b0;
                            op_bad   <= 1'b1;
                            state    <= S_RESP;
                        end
                    end
                end
                S_ARGS: begin
                    if (rx_fire) begin
                        case (idx)
                            3'd0:    addr[15:8]   <= rx_byte;
                            3'd1:    addr[7:0]    <= rx_byte;
                            3'd2:    wdata[7:0]   <= rx_byte;
                            3'd3:    wdata[15:8]  <= rx_byte;
                            3'd4:    wdata[23:16] <= rx_byte;
                            3'd5:    wdata[31:24] <= rx_byte;
                            default: ;
                        endcase
                        if (idx == args_last) begin
                            state <= S_MEM;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else if (tmo_hit) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (!op_write) rdata <= mem_rdata;
                        state <= S_RESP;
                        idx   <= '0;
                    end
                end
                default: begin
                    if (tx_ready) begin
                        if (idx == resp_last) begin
                            state <= S_IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        tx_byte = '0;
        if (state == S_RESP) begin
            if (op_bad)        tx_byte = 8'h3F;
            else if (op_write) tx_byte = 8'h4B;
            else begin
                case (idx[1:0])
                    2'd0:    tx_byte = rdata[7:0];
                    2'd1:    tx_byte = rdata[15:8];
                    2'd2:    tx_byte = rdata[23:16];
                    default: tx_byte = rdata[31:24];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed self-checking bench for uart_cmd_bridge (timeout scenario follows BRIDGE_TIMEOUT_EN).
module tb_uart_cmd_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        mem_valid;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        abort;

    int n_checks = 0;
    int n_fail   = 0;

    int          mem_cycles = 0;
    int          mem_txns   = 0;
    int          abort_cnt  = 0;
    logic        last_we;
    logic [15:0] last_addr;
    logic [31:0] last_wdata;
    logic [7:0]  tx_q[$];

    bit tie_high = 1'b0;
    int lat      = 0;

    uart_cmd_bridge #(.TIMEOUT_CYCLES(50)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_ready  (rx_ready),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .abort     (abort)
    );

    always #5 clock = ~clock;

    // Handshakes are stable at the falling edge, so a transfer seen here completes at the next rising edge.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_valid) begin
                mem_cycles <= mem_cycles + 1;
                if (mem_ready) begin
                    mem_txns   <= mem_txns + 1;
                    last_we    <= mem_we;
                    last_addr  <= mem_addr;
                    last_wdata <= mem_wdata;
                end
            end
            if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
            if (abort) abort_cnt <= abort_cnt + 1;
        end
    end

    // Bus responder: either always ready, or ready after lat cycles of mem_valid.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clock);
            #1;
            if (tie_high) mem_ready = 1'b1;
            else if (mem_valid && !mem_ready) begin
                if (wcnt >= lat) mem_ready = 1'b1;
                else             wcnt++;
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        rx_valid = 1'b1;
        rx_byte  = b;
        while (!rx_ready && waited < 200) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!rx_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte: rx_ready never rose for byte %02h", b);
        end
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        int waited;
        waited = 0;
        while (tx_q.size() < n && waited < 200) begin
            @(posedge clock); #1;
            waited++;
        end
        if (tx_q.size() < n) begin
            n_checks++; n_fail++;
            $display("FAIL wait_tx: got %0d bytes, required %0d", tx_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (rx_ready !== 1'b1)      begin n_fail++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_checks++; if (tx_valid !== 1'b0)      begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_byte !== 8'h00)      begin n_fail++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
        n_checks++; if (mem_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
        n_checks++; if (mem_we !== 1'b0)        begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== 16'h0)     begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0)    begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        n_checks++; if (abort !== 1'b0)         begin n_fail++; $display("FAIL reset_abort: got %b want 0", abort); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_write();
        int base, mbase;
        tie_high = 1'b1;
        tx_ready = 1'b1;
        base  = tx_q.size();
        mbase = mem_cycles;
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        n_checks++; if (mem_valid !== 1'b1)          begin n_fail++; $display("FAIL wr_mem_valid: got %b want 1", mem_valid); end
        n_checks++; if (mem_we !== 1'b1)             begin n_fail++; $display("FAIL wr_mem_we: got %b want 1", mem_we); end
        n_checks++; if (mem_addr !== 16'h0010)       begin n_fail++; $display("FAIL wr_mem_addr: got %h want 0010", mem_addr); end
        n_checks++; if (mem_wdata !== 32'hDEADBEEF)  begin n_fail++; $display("FAIL wr_mem_wdata: got %h want deadbeef", mem_wdata); end
        @(posedge clock); #1;
        n_checks++; if ({tx_valid, tx_byte} !== {1'b1, 8'h4B}) begin n_fail++; $display("FAIL wr_tx_k: got %b/%h want 1/4b", tx_valid, tx_byte); end
        n_checks++; if (mem_valid !== 1'b0)          begin n_fail++; $display("FAIL wr_mem_drop: got %b want 0", mem_valid); end
        @(posedge clock); #1;
        n_checks++; if ({rx_ready, tx_valid} !== 2'b10) begin n_fail++; $display("FAIL wr_back_idle: got %b want 10", {rx_ready, tx_valid}); end
        n_checks++; if (mem_cycles - mbase !== 1)    begin n_fail++; $display("FAIL wr_mem_cycles: got %0d want 1", mem_cycles - mbase); end
        n_checks++; if (tx_q.size() - base !== 1)    begin n_fail++; $display("FAIL wr_tx_count: got %0d want 1", tx_q.size() - base); end
        else begin
            n_checks++; if (tx_q[base] !== 8'h4B)    begin n_fail++; $display("FAIL wr_tx_byte: got %h want 4b", tx_q[base]); end
        end
    endtask

    task automatic test_read();
        int base, mbase, tbase;
        logic [7:0] exp [4];
        exp = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        tie_high  = 1'b0;
        lat       = 3;
        mem_rdata = 32'hCAFEF00D;
        base  = tx_q.size();
        mbase = mem_cycles;
        tbase = mem_txns;
        send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
        n_checks++; if ({mem_valid, mem_we} !== 2'b10) begin n_fail++; $display("FAIL rd_mem_req: got %b want 10", {mem_valid, mem_we}); end
        n_checks++; if (mem_addr !== 16'h1234)       begin n_fail++; $display("FAIL rd_mem_addr: got %h want 1234", mem_addr); end
        wait_tx(base + 4);
        repeat (4) @(posedge clock);
        #1;
        n_checks++; if (mem_cycles - mbase !== 4)    begin n_fail++; $display("FAIL rd_mem_cycles: got %0d want 4", mem_cycles - mbase); end
        n_checks++; if (mem_txns - tbase !== 1)      begin n_fail++; $display("FAIL rd_mem_txns: got %0d want 1", mem_txns - tbase); end
        n_checks++; if (tx_q.size() - base !== 4)    begin n_fail++; $display("FAIL rd_tx_count: got %0d want 4", tx_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            if (base + i < tx_q.size()) begin
                n_checks++;
                if (tx_q[base + i] !== exp[i]) begin n_fail++; $display("FAIL rd_tx_byte%0d: got %h want %h", i, tx_q[base + i], exp[i]); end
            end
        end
        lat = 0;
    endtask

    task automatic test_unknown();
        int base, mbase;
        logic [7:0] exp [5];
        exp = '{8'h3F, 8'h44, 8'h33, 8'h22, 8'h11};
        tie_high  = 1'b1;
        mem_rdata = 32'h11223344;
        base  = tx_q.size();
        mbase = mem_cycles;
        send_byte(8'h41);
        n_checks++; if ({tx_valid, tx_byte} !== {1'b1, 8'h3F}) begin n_fail++; $display("FAIL unk_tx_q: got %b/%h want 1/3f", tx_valid, tx_byte); end
        n_checks++; if (mem_valid !== 1'b0)          begin n_fail++; $display("FAIL unk_mem_valid: got %b want 0", mem_valid); end
        @(posedge clock); #1;
        n_checks++; if ({rx_ready, tx_valid} !== 2'b10) begin n_fail++; $display("FAIL unk_back_idle: got %b want 10", {rx_ready, tx_valid}); end
        n_checks++; if (mem_cycles - mbase !== 0)    begin n_fail++; $display("FAIL unk_no_bus: got %0d want 0", mem_cycles - mbase); end
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        wait_tx(base + 5);
        n_checks++; if ({last_we, last_addr} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL unk_rd_req: got %b/%h want 0/0000", last_we, last_addr); end
        for (int i = 0; i < 5; i++) begin
            if (base + i < tx_q.size()) begin
                n_checks++;
                if (tx_q[base + i] !== exp[i]) begin n_fail++; $display("FAIL unk_tx_byte%0d: got %h want %h", i, tx_q[base + i], exp[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int base, waited;
        logic [7:0] exp [4];
        exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        tie_high  = 1'b1;
        tx_ready  = 1'b0;
        mem_rdata = 32'hA1B2C3D4;
        base = tx_q.size();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h05);
        waited = 0;
        while (!tx_valid && waited < 50) begin @(posedge clock); #1; waited++; end
        mem_rdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({tx_valid, tx_byte} !== {1'b1, 8'hD4}) begin n_fail++; $display("FAIL bp_hold0_c%0d: got %b/%h want 1/d4", i, tx_valid, tx_byte); end
            @(posedge clock); #1;
        end
        tx_ready = 1'b1;
        @(posedge clock); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({tx_valid, tx_byte} !== {1'b1, 8'hC3}) begin n_fail++; $display("FAIL bp_hold1_c%0d: got %b/%h want 1/c3", i, tx_valid, tx_byte); end
            @(posedge clock); #1;
        end
        tx_ready = 1'b1;
        wait_tx(base + 4);
        repeat (5) @(posedge clock);
        #1;
        n_checks++; if (tx_q.size() - base !== 4)    begin n_fail++; $display("FAIL bp_tx_count: got %0d want 4", tx_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            if (base + i < tx_q.size()) begin
                n_checks++;
                if (tx_q[base + i] !== exp[i]) begin n_fail++; $display("FAIL bp_tx_byte%0d: got %h want %h", i, tx_q[base + i], exp[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, tbase;
        logic [7:0] exp [4];
        exp = '{8'h88, 8'h77, 8'h66, 8'h55};
        tie_high  = 1'b1;
        tx_ready  = 1'b1;
        mem_rdata = 32'h55667788;
        send_byte(8'h57); send_byte(8'h00);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_checks++; if ({rx_ready, mem_valid} !== 2'b10) begin n_fail++; $display("FAIL rm_idle: got %b want 10", {rx_ready, mem_valid}); end
        base  = tx_q.size();
        tbase = mem_txns;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
        n_checks++; if ({mem_valid, mem_we, mem_addr} !== {2'b10, 16'h0001}) begin n_fail++; $display("FAIL rm_req: got %b%b/%h want 10/0001", mem_valid, mem_we, mem_addr); end
        wait_tx(base + 4);
        n_checks++; if (mem_txns - tbase !== 1)      begin n_fail++; $display("FAIL rm_txns: got %0d want 1", mem_txns - tbase); end
        for (int i = 0; i < 4; i++) begin
            if (base + i < tx_q.size()) begin
                n_checks++;
                if (tx_q[base + i] !== exp[i]) begin n_fail++; $display("FAIL rm_tx_byte%0d: got %h want %h", i, tx_q[base + i], exp[i]); end
            end
        end
    endtask

    task automatic test_timeout();
        int base, mbase, abase;
        logic [7:0] exp [4];
        exp = '{8'h0D, 8'hF0, 8'hAD, 8'h0B};
        tie_high  = 1'b1;
        tx_ready  = 1'b1;
        mem_rdata = 32'h0BADF00D;
        mbase = mem_cycles;
        abase = abort_cnt;
        send_byte(8'h52); send_byte(8'h00);
        repeat (60) @(posedge clock);
        #1;
        n_checks++; if (mem_cycles - mbase !== 0)    begin n_fail++; $display("FAIL to_no_bus: got %0d want 0", mem_cycles - mbase); end
        n_checks++; if (rx_ready !== 1'b1)           begin n_fail++; $display("FAIL to_rx_ready: got %b want 1", rx_ready); end
`ifdef BRIDGE_TIMEOUT_EN
        n_checks++; if (abort_cnt - abase !== 1)     begin n_fail++; $display("FAIL to_abort: got %0d want 1", abort_cnt - abase); end
        base = tx_q.size();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h02);
`else
        n_checks++; if (abort_cnt - abase !== 0)     begin n_fail++; $display("FAIL to_abort: got %0d want 0", abort_cnt - abase); end
        base = tx_q.size();
        send_byte(8'h02);
`endif
        n_checks++; if ({mem_valid, mem_we, mem_addr} !== {2'b10, 16'h0002}) begin n_fail++; $display("FAIL to_req: got %b%b/%h want 10/0002", mem_valid, mem_we, mem_addr); end
        wait_tx(base + 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < tx_q.size()) begin
                n_checks++;
                if (tx_q[base + i] !== exp[i]) begin n_fail++; $display("FAIL to_tx_byte%0d: got %h want %h", i, tx_q[base + i], exp[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_unknown();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
